// File: rtl/shift_normalizer.sv
// Iterative left-shift normalizer: shifts an operand one bit per cycle until it is
// normalized (unsigned or two's complement) and reports the data and shift count.
module shift_normalizer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  out_shift,
   output logic                  out_zero,
   output logic                  out_sat
);

   localparam int MAX_CNT   = (1 << CNT_WIDTH) - 1;
   localparam int MAX_SHIFT = (MAX_CNT < DATA_WIDTH - 1) ? MAX_CNT : DATA_WIDTH - 1;
   localparam logic [CNT_WIDTH-1:0] MAX_SHIFT_C = CNT_WIDTH'(MAX_SHIFT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] work_q;
   logic                  signed_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [CNT_WIDTH-1:0]  out_shift_q;
   logic                  out_zero_q;
   logic                  out_sat_q;

   logic                  work_zero;
   logic                  work_norm;
   logic                  at_max;
   logic [DATA_WIDTH-1:0] work_d;

   // Signed operands are normalized once the top two bits differ (no redundant sign copy).
   always_comb begin
      work_zero = (work_q == {DATA_WIDTH{1'b0}});
      if (signed_q) begin
         work_norm = work_q[DATA_WIDTH-1] ^ work_q[DATA_WIDTH-2];
      end else begin
         work_norm = work_q[DATA_WIDTH-1];
      end
      at_max = (count_q == MAX_SHIFT_C);
      work_d = {work_q[DATA_WIDTH-2:0], 1'b0};
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_shift = out_shift_q;
   assign out_zero  = out_zero_q;
   assign out_sat   = out_sat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         work_q      <= {DATA_WIDTH{1'b0}};
         signed_q    <= 1'b0;
         count_q     <= {CNT_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_shift_q <= {CNT_WIDTH{1'b0}};
         out_zero_q  <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  work_q   <= in_data;
                  signed_q <= in_signed;
                  count_q  <= {CNT_WIDTH{1'b0}};
                  state_q  <= S_SHIFT;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SHIFT: begin
               // Zero outranks normalization, which outranks saturation.
               if (work_zero) begin
                  out_data_q  <= {DATA_WIDTH{1'b0}};
                  out_shift_q <= {CNT_WIDTH{1'b0}};
                  out_zero_q  <= 1'b1;
                  out_sat_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (work_norm) begin
                  out_data_q  <= work_q;
                  out_shift_q <= count_q;
                  out_zero_q  <= 1'b0;
                  out_sat_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else if (at_max) begin
                  out_data_q  <= work_q;
                  out_shift_q <= count_q;
                  out_zero_q  <= 1'b0;
                  out_sat_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  work_q  <= work_d;
                  count_q <= count_q + CNT_ONE;
                  state_q <= S_SHIFT;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  state_q <= S_DONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed bench for shift_normalizer: 8-bit and 16-bit instances, hand-computed vectors.
module tb_shift_normalizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, out_zero8, out_sat8;
   logic [7:0]  in_data8, out_data8;
   logic [2:0]  out_shift8;
   logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, out_zero16, out_sat16;
   logic [15:0] in_data16, out_data16;
   logic [2:0]  out_shift16;

   int tests_run = 0;
   int failed    = 0;

   typedef struct packed {
      logic [7:0] din; logic sgn; logic [7:0] lat;
      logic [7:0] dout; logic [2:0] sh; logic z; logic sat;
   } vec8_t;
   typedef struct packed {
      logic [15:0] din; logic sgn; logic [7:0] lat;
      logic [15:0] dout; logic [2:0] sh; logic z; logic sat;
   } vec16_t;

   shift_normalizer #(.DATA_WIDTH(8), .CNT_WIDTH(3)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .in_signed(in_signed8), .out_valid(out_valid8),
      .out_ready(out_ready8), .out_data(out_data8), .out_shift(out_shift8),
      .out_zero(out_zero8), .out_sat(out_sat8)
   );

   shift_normalizer #(.DATA_WIDTH(16), .CNT_WIDTH(3)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .in_data(in_data16), .in_signed(in_signed16), .out_valid(out_valid16),
      .out_ready(out_ready16), .out_data(out_data16), .out_shift(out_shift16),
      .out_zero(out_zero16), .out_sat(out_sat16)
   );

   task automatic accept8(input logic [7:0] d, input logic s);
      in_valid8 = 1'b1; in_data8 = d; in_signed8 = s;
      @(posedge clk); @(negedge clk);
      in_valid8 = 1'b0; in_data8 = 8'h00; in_signed8 = 1'b0;
   endtask

   task automatic wait8(output int lat);
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 40) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
   endtask

   task automatic release8();
      out_ready8 = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({out_valid8, out_data8, out_shift8, out_zero8, out_sat8, in_ready8} !== 15'h0) begin
         failed++;
         $display("FAIL reset8 got v=%b d=%h s=%0d z=%b sat=%b rdy=%b, expected all 0",
                  out_valid8, out_data8, out_shift8, out_zero8, out_sat8, in_ready8);
      end
      tests_run++;
      if ({out_valid16, out_data16, out_shift16, out_zero16, out_sat16, in_ready16} !== 23'h0) begin
         failed++;
         $display("FAIL reset16 got v=%b d=%h s=%0d z=%b sat=%b rdy=%b, expected all 0",
                  out_valid16, out_data16, out_shift16, out_zero16, out_sat16, in_ready16);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if ({in_ready8, in_ready16} !== 2'b11) begin
         failed++;
         $display("FAIL reset_release_ready got %b%b, expected 11", in_ready8, in_ready16);
      end
   endtask

   task automatic test_unsigned();
      vec8_t tbl[5];
      vec8_t got;
      tbl[0] = '{8'h01, 1'b0, 8'd8, 8'h80, 3'd7, 1'b0, 1'b0};
      tbl[1] = '{8'h80, 1'b0, 8'd1, 8'h80, 3'd0, 1'b0, 1'b0};
      tbl[2] = '{8'h00, 1'b0, 8'd1, 8'h00, 3'd0, 1'b1, 1'b0};
      tbl[3] = '{8'h10, 1'b0, 8'd4, 8'h80, 3'd3, 1'b0, 1'b0};
      tbl[4] = '{8'h5A, 1'b0, 8'd2, 8'hB4, 3'd1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         int lat;
         accept8(tbl[i].din, tbl[i].sgn);
         wait8(lat);
         got = '{tbl[i].din, tbl[i].sgn, lat[7:0], out_data8, out_shift8, out_zero8, out_sat8};
         tests_run++;
         if (got !== tbl[i]) begin
            failed++;
            $display("FAIL unsigned[%0d] got lat=%0d d=%h s=%0d z=%b sat=%b, expected lat=%0d d=%h s=%0d z=%b sat=%b",
                     i, lat, out_data8, out_shift8, out_zero8, out_sat8,
                     tbl[i].lat, tbl[i].dout, tbl[i].sh, tbl[i].z, tbl[i].sat);
         end
         release8();
         tests_run++;
         if ({out_valid8, in_ready8} !== 2'b01) begin
            failed++;
            $display("FAIL unsigned_release[%0d] got v=%b rdy=%b, expected v=0 rdy=1", i, out_valid8, in_ready8);
         end
      end
   endtask

   task automatic test_signed();
      vec8_t tbl[6];
      vec8_t got;
      tbl[0] = '{8'h00, 1'b1, 8'd1, 8'h00, 3'd0, 1'b1, 1'b0};
      tbl[1] = '{8'hF0, 1'b1, 8'd4, 8'h80, 3'd3, 1'b0, 1'b0};
      tbl[2] = '{8'h01, 1'b1, 8'd7, 8'h40, 3'd6, 1'b0, 1'b0};
      tbl[3] = '{8'hFF, 1'b1, 8'd8, 8'h80, 3'd7, 1'b0, 1'b0};
      tbl[4] = '{8'h40, 1'b1, 8'd1, 8'h40, 3'd0, 1'b0, 1'b0};
      tbl[5] = '{8'h20, 1'b1, 8'd2, 8'h40, 3'd1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         int lat;
         accept8(tbl[i].din, tbl[i].sgn);
         wait8(lat);
         got = '{tbl[i].din, tbl[i].sgn, lat[7:0], out_data8, out_shift8, out_zero8, out_sat8};
         tests_run++;
         if (got !== tbl[i]) begin
            failed++;
            $display("FAIL signed[%0d] got lat=%0d d=%h s=%0d z=%b sat=%b, expected lat=%0d d=%h s=%0d z=%b sat=%b",
                     i, lat, out_data8, out_shift8, out_zero8, out_sat8,
                     tbl[i].lat, tbl[i].dout, tbl[i].sh, tbl[i].z, tbl[i].sat);
         end
         release8();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      accept8(8'h01, 1'b0);
      lat = 0;
      while (out_valid8 !== 1'b1 && lat < 40) begin
         in_valid8 = ~in_valid8; in_data8 = 8'h55; in_signed8 = 1'b1;
         tests_run++;
         if (in_ready8 !== 1'b0) begin
            failed++;
            $display("FAIL bp_shift_ready cycle %0d got %b, expected 0", lat, in_ready8);
         end
         @(posedge clk); @(negedge clk);
         lat++;
      end
      tests_run++;
      if ({lat[7:0], out_data8, out_shift8, out_zero8, out_sat8} !== {8'd8, 8'h80, 3'd7, 1'b0, 1'b0}) begin
         failed++;
         $display("FAIL bp_result got lat=%0d d=%h s=%0d z=%b sat=%b, expected lat=8 d=80 s=7 z=0 sat=0",
                  lat, out_data8, out_shift8, out_zero8, out_sat8);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid8 = 1'b1; in_data8 = 8'h03; in_signed8 = 1'b0;
         @(posedge clk); @(negedge clk);
         tests_run++;
         if ({out_valid8, in_ready8, out_data8, out_shift8, out_zero8, out_sat8} !==
             {1'b1, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL bp_hold[%0d] got v=%b rdy=%b d=%h s=%0d z=%b sat=%b, expected v=1 rdy=0 d=80 s=7 z=0 sat=0",
                     c, out_valid8, in_ready8, out_data8, out_shift8, out_zero8, out_sat8);
         end
      end
      in_valid8 = 1'b0; in_data8 = 8'h00;
      release8();
      tests_run++;
      if ({out_valid8, in_ready8} !== 2'b01) begin
         failed++;
         $display("FAIL bp_release got v=%b rdy=%b, expected v=0 rdy=1", out_valid8, in_ready8);
      end
      accept8(8'h03, 1'b0);
      wait8(lat);
      tests_run++;
      if ({lat[7:0], out_data8, out_shift8, out_zero8, out_sat8} !== {8'd7, 8'hC0, 3'd6, 1'b0, 1'b0}) begin
         failed++;
         $display("FAIL bp_next got lat=%0d d=%h s=%0d, expected lat=7 d=c0 s=6", lat, out_data8, out_shift8);
      end
      release8();
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic seen;
      accept8(8'h01, 1'b0);
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      tests_run++;
      if ({out_valid8, out_data8, out_shift8, out_zero8, out_sat8, in_ready8} !== 15'h0) begin
         failed++;
         $display("FAIL midrst_outputs got v=%b d=%h s=%0d z=%b sat=%b rdy=%b, expected all 0",
                  out_valid8, out_data8, out_shift8, out_zero8, out_sat8, in_ready8);
      end
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); @(negedge clk);
         seen = seen | (out_valid8 !== 1'b0);
      end
      tests_run++;
      if (seen !== 1'b0) begin
         failed++;
         $display("FAIL midrst_no_valid got out_valid seen=%b, expected 0", seen);
      end
      accept8(8'h40, 1'b0);
      wait8(lat);
      tests_run++;
      if ({lat[7:0], out_data8, out_shift8, out_zero8, out_sat8} !== {8'd2, 8'h80, 3'd1, 1'b0, 1'b0}) begin
         failed++;
         $display("FAIL midrst_next got lat=%0d d=%h s=%0d z=%b sat=%b, expected lat=2 d=80 s=1 z=0 sat=0",
                  lat, out_data8, out_shift8, out_zero8, out_sat8);
      end
      release8();
   endtask

   task automatic test_wide();
      vec16_t tbl[4];
      vec16_t got;
      tbl[0] = '{16'h0001, 1'b0, 8'd8, 16'h0080, 3'd7, 1'b0, 1'b1};
      tbl[1] = '{16'h0100, 1'b0, 8'd8, 16'h8000, 3'd7, 1'b0, 1'b0};
      tbl[2] = '{16'h0000, 1'b0, 8'd1, 16'h0000, 3'd0, 1'b1, 1'b0};
      tbl[3] = '{16'hFFFF, 1'b1, 8'd8, 16'hFF80, 3'd7, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         int lat;
         in_valid16 = 1'b1; in_data16 = tbl[i].din; in_signed16 = tbl[i].sgn;
         @(posedge clk); @(negedge clk);
         in_valid16 = 1'b0; in_data16 = 16'h0000; in_signed16 = 1'b0;
         lat = 0;
         while (out_valid16 !== 1'b1 && lat < 40) begin
            @(posedge clk); @(negedge clk);
            lat++;
         end
         got = '{tbl[i].din, tbl[i].sgn, lat[7:0], out_data16, out_shift16, out_zero16, out_sat16};
         tests_run++;
         if (got !== tbl[i]) begin
            failed++;
            $display("FAIL wide[%0d] got lat=%0d d=%h s=%0d z=%b sat=%b, expected lat=%0d d=%h s=%0d z=%b sat=%b",
                     i, lat, out_data16, out_shift16, out_zero16, out_sat16,
                     tbl[i].lat, tbl[i].dout, tbl[i].sh, tbl[i].z, tbl[i].sat);
         end
         out_ready16 = 1'b1;
         @(posedge clk); @(negedge clk);
         out_ready16 = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid8 = 1'b0; in_data8 = 8'h00; in_signed8 = 1'b0; out_ready8 = 1'b0;
      in_valid16 = 1'b0; in_data16 = 16'h0000; in_signed16 = 1'b0; out_ready16 = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_backpressure();
      test_reset_mid();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
